// File: rtl/router_in_port_pkg.sv
// Packet type and byte-serial wire-format constants for the router inbound port.
package router_in_port_pkg;

  typedef struct packed {
    logic [3:0]  source_id;
    logic [3:0]  dest_id;
    logic [23:0] data;
  } pkt_t;

  localparam int unsigned BYTES_PER_PKT = 4;

  // Position of each link byte within a packet, in transmission order.
  localparam logic [1:0] BYTE_HDR      = 2'd0;
  localparam logic [1:0] BYTE_DATA_HI  = 2'd1;
  localparam logic [1:0] BYTE_DATA_MID = 2'd2;
  localparam logic [1:0] BYTE_DATA_LO  = 2'd3;

  typedef enum logic {StIdle, StRecv} rx_state_e;

  // Return pkt with the byte at wire position idx replaced by b.
  function automatic pkt_t pkt_set_byte(pkt_t pkt, logic [1:0] idx, logic [7:0] b);
    logic [31:0] raw;
    raw = pkt;
    case (idx)
      BYTE_HDR:      raw[31:24] = b;
      BYTE_DATA_HI:  raw[23:16] = b;
      BYTE_DATA_MID: raw[15:8]  = b;
      BYTE_DATA_LO:  raw[7:0]   = b;
      default:       raw        = raw;
    endcase
    return pkt_t'(raw);
  endfunction

endpackage

// File: rtl/router_in_port_if.sv
// Link (put/payload/free) and core pop (pkt_*) signals of the router inbound port.
// ROUTER_IN_ERR_EN adds the err_trunc / drop_cnt error-reporting signals.
interface router_in_port_if
  import router_in_port_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) ();

  logic                     put;
  logic [7:0]               payload;
  logic                     free;
  pkt_t                     pkt_out;
  logic                     pkt_valid;
  logic                     pkt_ready;
  logic [$clog2(DEPTH):0]   occupancy;
`ifdef ROUTER_IN_ERR_EN
  logic                     err_trunc;
  logic [7:0]               drop_cnt;

  modport master (
    output put, payload, pkt_ready,
    input  free, pkt_out, pkt_valid, occupancy, err_trunc, drop_cnt
  );
  modport slave (
    input  put, payload, pkt_ready,
    output free, pkt_out, pkt_valid, occupancy, err_trunc, drop_cnt
  );
`else
  modport master (
    output put, payload, pkt_ready,
    input  free, pkt_out, pkt_valid, occupancy
  );
  modport slave (
    input  put, payload, pkt_ready,
    output free, pkt_out, pkt_valid, occupancy
  );
`endif

endinterface

// File: rtl/pkt_fifo.sv
// DEPTH-entry packet FIFO: combinational head read, simultaneous push/pop, full/empty/count.
module pkt_fifo
  import router_in_port_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   push,
  input  pkt_t                   push_pkt,
  input  logic                   pop,
  output pkt_t                   head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [AddrW:0] FullCnt = (AddrW + 1)'(DEPTH);

  pkt_t             mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO can still accept a push when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AddrW + 1)'(1);
        2'b01:   count_q <= count_q - (AddrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_pkt;
  end

  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/router_in_port.sv
// Router inbound port: deserializes 4-byte put/payload packets into a FIFO popped by the core.
// Optional ROUTER_IN_ERR_EN adds err_trunc pulse and saturating drop_cnt.
module router_in_port
  import router_in_port_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ROUTERID = 0
) (
  input logic             clk,
  input logic             rst_b,
  router_in_port_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  rx_state_e       state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  pkt_t            asm_q, asm_d, asm_next;
  logic            push, full, empty;
  pkt_t            head;
  logic [CntW-1:0] count;

  assign asm_next = pkt_set_byte(asm_q, byte_cnt_q, bus.payload);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    push       = 1'b0;
    bus.free   = 1'b0;
    case (state_q)
      StIdle: begin
        bus.free = ~full;
        // A put while full is a protocol violation and is ignored.
        if (bus.put && !full) begin
          asm_d      = asm_next;
          byte_cnt_d = 2'd1;
          state_d    = StRecv;
        end
      end
      StRecv: begin
        if (!bus.put) begin
          byte_cnt_d = '0;
          state_d    = StIdle;
        end else if (byte_cnt_q == BYTE_DATA_LO) begin
          asm_d      = asm_next;
          push       = 1'b1;
          byte_cnt_d = '0;
          state_d    = StIdle;
        end else begin
          asm_d      = asm_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  pkt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_b    (rst_b),
    .push     (push),
    .push_pkt (asm_next),
    .pop      (bus.pkt_ready),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign bus.pkt_out   = head;
  assign bus.pkt_valid = ~empty;
  assign bus.occupancy = count;

`ifdef ROUTER_IN_ERR_EN
  logic       drop;
  logic       err_trunc_q;
  logic [7:0] drop_cnt_q;

  assign drop = ((state_q == StIdle) && bus.put && full) || ((state_q == StRecv) && !bus.put);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      err_trunc_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      err_trunc_q <= drop;
      if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign bus.err_trunc = err_trunc_q;
  assign bus.drop_cnt  = drop_cnt_q;
`endif

  // Slot reservation makes an unpopped push into a full FIFO unreachable.
  assert property (@(posedge clk) disable iff (!rst_b) !(push && full && !bus.pkt_ready))
    else $error("router_in_port %0d: push into full FIFO without pop", ROUTERID);

endmodule

// File: tb/tb_router_in_port.sv
// Bench for router_in_port: directed scenarios plus random traffic against a queue-based model.
module tb_router_in_port;
  import router_in_port_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  router_in_port_if #(.DEPTH(DEPTH)) bus ();

  router_in_port #(
    .DEPTH    (DEPTH),
    .ROUTERID (3)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of whole packets plus the bytes of the packet currently arriving.
  logic [31:0] mq[$];
  logic [7:0]  part[$];
  bit          in_pkt;
  int          drops;
  bit          err_exp;
  int          pre_sz;
  bit          drop_now;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mq.delete();
      part.delete();
      in_pkt  = 1'b0;
      drops   = 0;
      err_exp = 1'b0;
    end else begin
      pre_sz   = mq.size();
      drop_now = 1'b0;
      if (bus.pkt_ready && pre_sz > 0) void'(mq.pop_front());
      if (!in_pkt) begin
        if (bus.put) begin
          if (pre_sz < DEPTH) begin
            part.delete();
            part.push_back(bus.payload);
            in_pkt = 1'b1;
          end else begin
            drop_now = 1'b1;
          end
        end
      end else if (bus.put) begin
        part.push_back(bus.payload);
        if (part.size() == BYTES_PER_PKT) begin
          mq.push_back({part[0], part[1], part[2], part[3]});
          in_pkt = 1'b0;
        end
      end else begin
        in_pkt   = 1'b0;
        drop_now = 1'b1;
      end
      err_exp = drop_now;
      if (drop_now && drops < 255) drops++;
    end
  end

  always @(negedge clk) begin
    check("free", bus.free, 32'(!in_pkt && mq.size() < DEPTH));
    check("pkt_valid", bus.pkt_valid, 32'(mq.size() > 0));
    check("pkt_out", bus.pkt_out, (mq.size() > 0) ? mq[0] : 32'h0);
    check("occupancy", bus.occupancy, mq.size());
`ifdef ROUTER_IN_ERR_EN
    check("err_trunc", bus.err_trunc, 32'(err_exp));
    check("drop_cnt", bus.drop_cnt, drops);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ready_mode: 0 leave pkt_ready alone, 1 random per byte, 2 ready only on the last byte.
  task automatic send_pkt(input logic [31:0] p, input int nbytes, input int ready_mode);
    for (int i = 0; i < nbytes; i++) begin
      bus.put     = 1'b1;
      bus.payload = p[31-8*i -: 8];
      if (ready_mode == 1) bus.pkt_ready = 1'($urandom_range(0, 1));
      else if (ready_mode == 2) bus.pkt_ready = (i == 3);
      tick();
    end
    bus.put     = 1'b0;
    bus.payload = '0;
    if (ready_mode == 2) bus.pkt_ready = 1'b0;
  endtask

  task automatic wait_free(input int limit);
    int n;
    n = 0;
    while (!bus.free && n < limit) begin
      bus.pkt_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("free before packet", bus.free, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  int          gap;
  int          nb;
  logic [31:0] rp;

  initial begin
    rst_b         = 1'b0;
    bus.put       = 1'b0;
    bus.payload   = '0;
    bus.pkt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset free", bus.free, 1);
    check("reset pkt_valid", bus.pkt_valid, 0);
    check("reset pkt_out", bus.pkt_out, 0);
    check("reset occupancy", bus.occupancy, 0);
    rst_b = 1'b1;
    tick();

    // Single packet: visible right after the edge that samples byte 3.
    send_pkt(32'h2A123456, 4, 0);
    check("single pkt_valid", bus.pkt_valid, 1);
    check("single pkt_out", bus.pkt_out, 32'h2A123456);
    check("single occupancy", bus.occupancy, 1);
    check("model head single", mq[0], 32'h2A123456);

    // Truncation after two bytes.
    send_pkt(32'h33AA0000, 2, 0);
    tick();
    check("trunc occupancy", bus.occupancy, 1);
    check("trunc free", bus.free, 1);
    check("trunc head", bus.pkt_out, 32'h2A123456);
`ifdef ROUTER_IN_ERR_EN
    check("trunc err pulse", bus.err_trunc, 1);
    check("trunc drop_cnt", bus.drop_cnt, 1);
    tick();
    check("trunc err ends", bus.err_trunc, 0);
`endif
    bus.pkt_ready = 1'b1;
    tick();
    bus.pkt_ready = 1'b0;
    check("single popped", bus.occupancy, 0);

    // Fill to DEPTH, back to back.
    for (int i = 0; i < 4; i++) send_pkt(32'h10000001 + i, 4, 0);
    check("full free", bus.free, 0);
    check("full occupancy", bus.occupancy, 4);

    // Put while full is ignored.
    bus.put     = 1'b1;
    bus.payload = 8'h77;
    tick();
    bus.put     = 1'b0;
    bus.payload = '0;
    check("ignored put occupancy", bus.occupancy, 4);
    check("ignored put free", bus.free, 0);
`ifdef ROUTER_IN_ERR_EN
    check("ignored put drop_cnt", bus.drop_cnt, 2);
`endif
    tick();

    check("pop order 1", bus.pkt_out, 32'h10000001);
    bus.pkt_ready = 1'b1;
    tick();
    bus.pkt_ready = 1'b0;
    check("free after pop", bus.free, 1);
    check("occupancy after pop", bus.occupancy, 3);
    check("pop order 2", bus.pkt_out, 32'h10000002);
    bus.pkt_ready = 1'b1;
    tick();
    bus.pkt_ready = 1'b0;

    // Push and pop on the same edge.
    send_pkt(32'h10000005, 4, 2);
    check("simul occupancy", bus.occupancy, 2);
    check("simul head", bus.pkt_out, 32'h10000004);
    bus.pkt_ready = 1'b1;
    tick();
    check("simul next", bus.pkt_out, 32'h10000005);
    tick();
    bus.pkt_ready = 1'b0;
    check("drained", bus.occupancy, 0);

    // Asynchronous reset in the middle of a packet.
    send_pkt(32'hCAFEBABE, 4, 0);
    send_pkt(32'h12345678, 2, 0);
    #2 rst_b = 1'b0;
    #1;
    check("midreset free", bus.free, 1);
    check("midreset pkt_valid", bus.pkt_valid, 0);
    check("midreset occupancy", bus.occupancy, 0);
    check("midreset pkt_out", bus.pkt_out, 0);
    tick();
    rst_b = 1'b1;
    tick();
    send_pkt(32'hF0FFEEDD, 4, 0);
    check("post reset pkt", bus.pkt_out, 32'hF0FFEEDD);
    check("post reset occupancy", bus.occupancy, 1);
    bus.pkt_ready = 1'b1;
    tick();

    // Random traffic: gaps, occasional truncation, random pops.
    for (int n = 0; n < 80; n++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        bus.pkt_ready = 1'($urandom_range(0, 1));
        tick();
      end
      wait_free(64);
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 4;
      rp = $urandom;
      send_pkt(rp, nb, 1);
    end
    bus.pkt_ready = 1'b1;
    repeat (8) tick();
    check("final drain", bus.occupancy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
